// File: rtl/ysyx_22041071_rd_arb_if.sv
// Read-request bundle between the IF/LS requesters, the arbiter and the
// AXI read master's CPU-side port.
interface ysyx_22041071_rd_arb_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_valid;
   logic [ADDR_W-1:0] if_addr;
   logic [1:0]        if_size;
   logic              if_ready;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic [1:0]        if_rresp;

   logic              ls_valid;
   logic [ADDR_W-1:0] ls_addr;
   logic [1:0]        ls_size;
   logic              ls_ready;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;
   logic [1:0]        ls_rresp;

   logic              rd_valid;
   logic              rd_ready;
   logic [3:0]        rd_id;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_len;
   logic [1:0]        rd_size;
   logic              rd_rsp_valid;
   logic [3:0]        rd_rsp_id;
   logic [DATA_W-1:0] rd_rsp_data;
   logic [1:0]        rd_rsp_resp;

   logic              busy;

   modport master (
      input  if_valid, if_addr, if_size,
      output if_ready, if_rvalid, if_rdata, if_rresp,
      input  ls_valid, ls_addr, ls_size,
      output ls_ready, ls_rvalid, ls_rdata, ls_rresp,
      output rd_valid, rd_id, rd_addr, rd_len, rd_size,
      input  rd_ready,
      input  rd_rsp_valid, rd_rsp_id, rd_rsp_data, rd_rsp_resp,
      output busy
   );

   modport slave (
      output if_valid, if_addr, if_size,
      input  if_ready, if_rvalid, if_rdata, if_rresp,
      output ls_valid, ls_addr, ls_size,
      input  ls_ready, ls_rvalid, ls_rdata, ls_rresp,
      input  rd_valid, rd_id, rd_addr, rd_len, rd_size,
      output rd_ready,
      output rd_rsp_valid, rd_rsp_id, rd_rsp_data, rd_rsp_resp,
      input  busy
   );
endinterface

// File: rtl/ysyx_22041071_rd_arb.sv
// Round-robin IF/LS read arbiter with single outstanding read,
// size-aware response routing and a lost-response watchdog.
module ysyx_22041071_rd_arb #(
   parameter int         ADDR_W  = 64,
   parameter int         DATA_W  = 64,
   parameter int         TIMEOUT = 1024,
   parameter logic [3:0] IF_ID   = 4'd0,
   parameter logic [3:0] LS_ID   = 4'd1
) (
   input logic                  clk,
   input logic                  reset_n,
   ysyx_22041071_rd_arb_if.master bus
);
   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN
   } state_t;

   state_t            r_state;
   state_t            w_nxt;
   logic              r_last_ls;
   logic              r_to;
   logic [CW-1:0]     r_cnt;
   logic [3:0]        r_id;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_ls_rdata;
   logic [1:0]        r_if_rresp;
   logic [1:0]        r_ls_rresp;

   logic              w_gnt_if;
   logic              w_gnt_ls;
   logic              w_hit;
   logic              w_to;
   logic [DATA_W-1:0] w_sh_d;
   logic [DATA_W-1:0] w_proc;

   assign w_hit = bus.rd_rsp_valid && (bus.rd_rsp_id == r_id);
   assign w_to  = (r_cnt == CW'(TIMEOUT - 1));

   // Response lanes are byte-positioned; right-justify by low address bits
   assign w_sh_d = bus.rd_rsp_data >> {r_addr[2:0], 3'b000};

   always_comb begin
      w_proc = w_sh_d;
      unique case (r_size)
         2'b00:   w_proc = {{(DATA_W-8){1'b0}}, w_sh_d[7:0]};
         2'b01:   w_proc = {{(DATA_W-16){1'b0}}, w_sh_d[15:0]};
         2'b10:   w_proc = {{(DATA_W-32){1'b0}}, w_sh_d[31:0]};
         default: w_proc = w_sh_d;
      endcase
   end

   always_comb begin
      w_nxt    = r_state;
      w_gnt_if = 1'b0;
      w_gnt_ls = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.if_valid && bus.ls_valid) begin
               w_gnt_if = r_last_ls;
               w_gnt_ls = !r_last_ls;
            end else begin
               w_gnt_if = bus.if_valid;
               w_gnt_ls = bus.ls_valid;
            end
            if (w_gnt_if || w_gnt_ls) w_nxt = S_REQ;
         end
         S_REQ:   if (bus.rd_ready) w_nxt = S_WAIT;
         S_WAIT:  if (w_hit || w_to) w_nxt = S_RESP;
         S_RESP:  w_nxt = r_to ? S_DRAIN : S_IDLE;
         S_DRAIN: if (w_hit) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_last_ls  <= 1'b0;
         r_to       <= 1'b0;
         r_cnt      <= '0;
         r_id       <= '0;
         r_addr     <= '0;
         r_size     <= '0;
         r_if_rdata <= '0;
         r_ls_rdata <= '0;
         r_if_rresp <= '0;
         r_ls_rresp <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_gnt_if || w_gnt_ls) begin
            r_last_ls <= w_gnt_ls;
            r_id      <= w_gnt_ls ? LS_ID : IF_ID;
            r_addr    <= w_gnt_ls ? bus.ls_addr : bus.if_addr;
            r_size    <= w_gnt_ls ? bus.ls_size : bus.if_size;
         end
         if (r_state == S_REQ && bus.rd_ready) r_cnt <= '0;
         else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
         // A real response beats a watchdog expiry in the same cycle
         if (r_state == S_WAIT && (w_hit || w_to)) begin
            r_to <= !w_hit;
            if (r_last_ls) begin
               r_ls_rdata <= w_hit ? w_proc : '0;
               r_ls_rresp <= w_hit ? bus.rd_rsp_resp : 2'b10;
            end else begin
               r_if_rdata <= w_hit ? w_proc : '0;
               r_if_rresp <= w_hit ? bus.rd_rsp_resp : 2'b10;
            end
         end
      end
   end

   assign bus.if_ready  = w_gnt_if;
   assign bus.ls_ready  = w_gnt_ls;
   assign bus.if_rvalid = (r_state == S_RESP) && !r_last_ls;
   assign bus.ls_rvalid = (r_state == S_RESP) && r_last_ls;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.ls_rdata  = r_ls_rdata;
   assign bus.if_rresp  = r_if_rresp;
   assign bus.ls_rresp  = r_ls_rresp;
   assign bus.rd_valid  = (r_state == S_REQ);
   assign bus.rd_id     = r_id;
   assign bus.rd_addr   = r_addr;
   assign bus.rd_len    = 8'd0;
   assign bus.rd_size   = r_size;
   assign bus.busy      = (r_state != S_IDLE);
endmodule
